// File: rtl/nco_pdm_pkg.sv
// Shared types and helpers for the NCO + PDM generator: waveform mode encoding
// and the midscale code for a given sample width.
package nco_pdm_pkg;

  typedef enum logic [1:0] {
    MODE_SAW = 2'b00,
    MODE_TRI = 2'b01,
    MODE_SQR = 2'b10,
    MODE_MID = 2'b11
  } mode_e;

  function automatic logic [31:0] midscale(input int width);
    return 32'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/pdm_modulator.sv
// Sample-to-bitstream modulator. First-order error accumulator by default;
// define NCO_PDM_SECOND_ORDER_EN for a second-order error-feedback loop.
module pdm_modulator
  import nco_pdm_pkg::*;
#(
  parameter int DAC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [DAC_W-1:0] w,
  output logic             pdm_out
);

  logic pdm_q, pdm_d;

`ifdef NCO_PDM_SECOND_ORDER_EN
  localparam int IW = DAC_W + 3;

  logic signed [IW-1:0] i1_q, i1_d, i2_q, i2_d;
  logic signed [IW-1:0] mid, x, fb;
  logic                 bit_q, bit_d;

  // Input is recentred about midscale; feedback swings +/- midscale from the last decision.
  always_comb begin
    mid  = IW'(midscale(DAC_W));
    x    = $signed({3'b000, w}) - mid;
    fb   = bit_q ? mid : -mid;
    i1_d = i1_q;
    i2_d = i2_q;
    bit_d = bit_q;
    if (en) begin
      i1_d  = i1_q + x - fb;
      i2_d  = i2_q + i1_d - fb;
      bit_d = ~i2_d[IW-1];
    end
    pdm_d = en & bit_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i1_q  <= '0;
      i2_q  <= '0;
      bit_q <= 1'b0;
      pdm_q <= 1'b0;
    end else begin
      i1_q  <= i1_d;
      i2_q  <= i2_d;
      bit_q <= bit_d;
      pdm_q <= pdm_d;
    end
  end
`else
  logic [DAC_W:0]   sum;
  logic [DAC_W-1:0] err_q, err_d;

  always_comb begin
    sum   = {1'b0, err_q} + {1'b0, w};
    err_d = en ? sum[DAC_W-1:0] : err_q;
    pdm_d = en & sum[DAC_W];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= '0;
      pdm_q <= 1'b0;
    end else begin
      err_q <= err_d;
      pdm_q <= pdm_d;
    end
  end
`endif

  assign pdm_out = pdm_q;

endmodule

// File: rtl/nco_pdm_gen2.sv
// Phase-accumulator NCO with shadowed frequency word, waveform shaping and PDM
// output. NCO_PDM_SECOND_ORDER_EN selects the second-order modulator.
module nco_pdm_gen2
  import nco_pdm_pkg::*;
#(
  parameter int ACC_W = 24,
  parameter int FCW_W = 16,
  parameter int DAC_W = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [FCW_W-1:0] fcw_data,
  input  logic             fcw_valid,
  output logic             fcw_ready,
  input  logic [1:0]       mode,
  input  logic             phase_sync,
  output logic             wrap,
  output logic             pdm_out
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [FCW_W-1:0] fcw_active_q, fcw_active_d;
  logic [FCW_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             wrap_q, wrap_d;
  logic [ACC_W:0]   acc_sum;
  logic             carry, hs, xfer;
  logic [DAC_W-1:0] w;
  mode_e            mode_sel;

  // A word accepted this cycle is not yet pending, so it can never transfer on the same edge.
  always_comb begin
    acc_sum = {1'b0, acc_q} + {{(ACC_W - FCW_W + 1){1'b0}}, fcw_active_q};
    carry   = en & acc_sum[ACC_W];
    hs      = fcw_valid & ~pending_q;
    xfer    = pending_q & (carry | phase_sync | ~en | (fcw_active_q == '0));

    acc_d = acc_q;
    if (phase_sync)
      acc_d = '0;
    else if (en)
      acc_d = acc_sum[ACC_W-1:0];

    wrap_d = carry & ~phase_sync;

    pending_d = pending_q;
    if (hs)
      pending_d = 1'b1;
    else if (xfer)
      pending_d = 1'b0;

    shadow_d     = hs ? fcw_data : shadow_q;
    fcw_active_d = xfer ? shadow_q : fcw_active_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q        <= '0;
      fcw_active_q <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      wrap_q       <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      fcw_active_q <= fcw_active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      wrap_q       <= wrap_d;
    end
  end

  always_comb begin
    mode_sel = mode_e'(mode);
    case (mode_sel)
      MODE_SAW: w = acc_q[ACC_W-1 -: DAC_W];
      MODE_TRI: w = acc_q[ACC_W-2 -: DAC_W] ^ {DAC_W{acc_q[ACC_W-1]}};
      MODE_SQR: w = {DAC_W{acc_q[ACC_W-1]}};
      default:  w = DAC_W'(midscale(DAC_W));
    endcase
  end

  pdm_modulator #(
    .DAC_W(DAC_W)
  ) u_mod (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .w      (w),
    .pdm_out(pdm_out)
  );

  assign fcw_ready = ~pending_q;
  assign wrap      = wrap_q;

endmodule

// File: doc/nco_pdm_gen2.md
NCO_PDM_GEN2 -- requirements
Module: nco_pdm_gen2

Interface
REQ-001 Parameter ACC_W, default 24: phase accumulator width; legal range 12..32.
REQ-002 Parameter FCW_W, default 16: frequency control word width; FCW_W SHALL be at most ACC_W.
REQ-003 Parameter DAC_W, default 10: waveform sample width fed to the modulator; DAC_W SHALL be at most ACC_W-2.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst  in  1  synchronous reset, active-high.
REQ-006 en  in  1  run enable.
REQ-007 fcw_data  in  FCW_W  new frequency control word.
REQ-008 fcw_valid  in  1  fcw_data offered.
REQ-009 fcw_ready  out  1  shadow register empty; a word can be accepted.
REQ-010 mode  in  2  waveform select: 00 saw, 01 triangle, 10 square, 11 midscale.
REQ-011 phase_sync  in  1  clear the phase accumulator.
REQ-012 wrap  out  1  one-cycle pulse on accumulator carry-out.
REQ-013 pdm_out  out  1  registered PDM bitstream.

Function
REQ-014 When en=1, acc SHALL update as acc <= (acc + zero-extended fcw_active) mod 2^ACC_W; when en=0, acc SHALL hold.
REQ-015 wrap SHALL be asserted, registered, in the cycle following an update whose addition carries out of bit ACC_W-1; it SHALL otherwise be 0.
REQ-016 The handshake SHALL complete on a cycle with fcw_valid=1 and fcw_ready=1; that cycle SHALL load the shadow register and set pending=1, and fcw_ready SHALL then be 0 while pending=1.
REQ-017 A pending word SHALL move to fcw_active, and clear pending, on the first cycle in which any of these holds: the accumulator carries out, phase_sync=1, en=0, or fcw_active=0.
REQ-018 A handshake completing in the same cycle as a carry-out SHALL wait for the next transfer condition; it SHALL NOT be transferred in that cycle.
REQ-019 Waveform sample w (combinational from acc, DAC_W bits) SHALL be defined per mode:
  - saw: acc[ACC_W-1 -: DAC_W].
  - triangle: acc[ACC_W-2 -: DAC_W] XOR replicated acc[ACC_W-1].
  - square: all ones when acc[ACC_W-1]=1, otherwise all zeros.
  - midscale: 2^(DAC_W-1).
REQ-020 A mode change SHALL take effect on the next modulator update, with no phase reset.
REQ-021 The first-order modulator SHALL compute sum = err + w in DAC_W+1 bits, then update pdm_out <= sum[DAC_W] and err <= sum[DAC_W-1:0]; long-run ones density SHALL be w/2^DAC_W.
REQ-022 When en=0, err SHALL hold and pdm_out SHALL be driven 0 from the next edge.
REQ-023 phase_sync=1 SHALL set acc to 0 on the next edge regardless of en; err SHALL be unaffected; it has priority over accumulation, and wrap SHALL NOT pulse for that cycle even when a carry would have occurred.
REQ-024 The latency from an acc value to its pdm_out bit SHALL be 1 cycle.

Reset
REQ-025 With rst=1, the next edge SHALL clear acc, err, fcw_active, the shadow register, pending, pdm_out and wrap, and set fcw_ready=1; all handshakes SHALL be ignored during reset.
REQ-026 Reset mid-operation SHALL discard any pending word.

Configuration
REQ-027 Macro NCO_PDM_SECOND_ORDER_EN defined: the modulator SHALL be a second-order error-feedback loop, with signed integrators of DAC_W+3 bits, pdm_out = NOT sign(i2), and a feedback of ±2^(DAC_W-1) about midscale; long-run density SHALL match REQ-021 within 1/2^DAC_W.
REQ-028 Macro undefined: the first-order modulator of REQ-021 SHALL be used; port list and latency are identical in both builds.

Structure
REQ-029 Package nco_pdm_pkg SHALL hold the mode typedef (2-bit enum), the MODE_SAW, MODE_TRI, MODE_SQR and MODE_MID constants, and the midscale helper function.
REQ-030 Sub-module pdm_modulator (input w, en; output pdm_out; order selected by the macro) SHALL be instantiated once; the accumulator, handshake and waveform logic stay in nco_pdm_gen2.

Verification
REQ-031 Reset: after rst pulse -> pdm_out=0, wrap=0, fcw_ready=1, acc=0.
REQ-032 Midscale: mode=11, en=1, first-order build -> pdm_out alternates 0,1,0,1 from the second cycle after reset release.
REQ-033 Wrap period: defaults, fcw=0x8000 loaded, en=1 -> wrap pulses exactly every 512 cycles; saw-mode ones count per period = 256 ±1.
REQ-034 Handshake: load 0x4000 while running at 0x8000 -> fcw_ready=0 until the next carry; the period changes 512->1024 cycles starting at that wrap; a second valid held high during pending is accepted only after the transfer.
REQ-035 Sync collision: phase_sync=1 on the carry cycle -> acc=0 on the next edge, no wrap pulse, pending word transferred.
REQ-036 Disable: en=0 mid-period -> pdm_out=0 next edge, acc held; a word loaded while disabled becomes active immediately, and wrap timing resumes from the held acc.
